rv32_multicycle_core: RTL

- Parametrised successor to the team's single-cycle RV32 CPU.
- Executes full RV32I: ALU, shifts, SLT/SLTU, all branches, JAL/JALR, LUI/AUIPC, byte/half/word loads and stores.
- Runs as a multi-cycle FSM over one shared instruction/data memory port with a req/ready handshake, so it tolerates wait states.
- Adds RV32E mode, a configurable reset vector, trap/halt reporting and a retire strobe for the verification monitor.

---
 rtl/rv32_multicycle_core.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_multicycle_core.sv
// rv32_multicycle_core: multi-cycle RV32I/E core on one shared
// req/ready memory port, with halt/trap and retire reporting.
module rv32_multicycle_core #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          NUM_REGS      = 32,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        illegal
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;
  state_t r_state, w_next;

  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm;
  logic [31:0] r_res, r_npc, r_ea;
  logic        r_illegal;
  logic [31:0] r_regs [NUM_REGS];

  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd, w_rs1, w_rs2;
  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld;
  logic w_st, w_opi, w_opr, w_fence, w_sys;
  assign w_lui   = (w_op == OP_LUI);
  assign w_auipc = (w_op == OP_AUIPC);
  assign w_jal   = (w_op == OP_JAL);
  assign w_jalr  = (w_op == OP_JALR);
  assign w_br    = (w_op == OP_BR);
  assign w_ld    = (w_op == OP_LD);
  assign w_st    = (w_op == OP_ST);
  assign w_opi   = (w_op == OP_IMM);
  assign w_opr   = (w_op == OP_ALU);
  assign w_fence = (w_op == OP_FENCE);
  assign w_sys   = (w_op == OP_SYS);

  logic w_legal, w_use1, w_use2, w_has_rd;
  always_comb begin
    w_legal  = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_has_rd = 1'b0;
    unique case (1'b1)
      w_lui, w_auipc, w_jal: begin
        w_legal  = 1'b1;
        w_has_rd = 1'b1;
      end
      w_jalr: begin
        w_legal  = (w_f3 == 3'b000);
        w_use1   = 1'b1;
        w_has_rd = 1'b1;
      end
      w_br: begin
        w_legal = (w_f3[2:1] != 2'b01);
        w_use1  = 1'b1;
        w_use2  = 1'b1;
      end
      w_ld: begin
        w_legal  = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
        w_use1   = 1'b1;
        w_has_rd = 1'b1;
      end
      w_st: begin
        w_legal = !w_f3[2] && (w_f3[1:0] != 2'b11);
        w_use1  = 1'b1;
        w_use2  = 1'b1;
      end
      w_opi: begin
        w_legal = 1'b1;
        if (w_f3 == 3'b001)
          w_legal = (w_f7 == 7'h00);
        if (w_f3 == 3'b101)
          w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        w_use1   = 1'b1;
        w_has_rd = 1'b1;
      end
      w_opr: begin
        w_legal = (w_f7 == 7'h00) ||
                  ((w_f7 == 7'h20) &&
                   ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_has_rd = 1'b1;
      end
      w_fence: w_legal = 1'b1;
      w_sys: w_legal = (r_ir[31:21] == '0) && (r_ir[19:7] == '0);
      default: ;
    endcase
  end

  logic w_bad_idx, w_dec_ok;
  assign w_bad_idx = (w_use1 && ({1'b0, w_rs1} >= 6'(NUM_REGS))) ||
                     (w_use2 && ({1'b0, w_rs2} >= 6'(NUM_REGS))) ||
                     (w_has_rd && ({1'b0, w_rd} >= 6'(NUM_REGS)));
  assign w_dec_ok  = w_legal && !w_bad_idx;

  logic [31:0] w_imm, w_rs1v, w_rs2v;
  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    unique case (1'b1)
      w_st: w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      w_br: w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                     r_ir[30:25], r_ir[11:8], 1'b0};
      w_lui, w_auipc: w_imm = {r_ir[31:12], 12'h000};
      w_jal: w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12],
                      r_ir[20], r_ir[30:21], 1'b0};
      default: ;
    endcase
  end
  assign w_rs1v = (w_rs1 == '0) ? '0 : r_regs[w_rs1[RW-1:0]];
  assign w_rs2v = (w_rs2 == '0) ? '0 : r_regs[w_rs2[RW-1:0]];

  logic [31:0] w_op2, w_sra, w_alu, w_pc4, w_pcimm;
  logic [31:0] w_npc, w_ea, w_res;
  logic [4:0]  w_sh;
  logic        w_take, w_mis, w_fault, w_ecall_halt;
  assign w_op2   = w_opr ? r_b : r_imm;
  assign w_sh    = w_op2[4:0];
  assign w_sra   = $signed(r_a) >>> w_sh;
  assign w_pc4   = r_pc + 32'd4;
  assign w_pcimm = r_pc + r_imm;
  assign w_ea    = r_a + r_imm;

  always_comb begin
    w_alu = '0;
    unique case (w_f3)
      3'b000: w_alu = (w_opr && r_ir[30]) ? r_a - w_op2 : r_a + w_op2;
      3'b001: w_alu = r_a << w_sh;
      3'b010: w_alu = {31'b0, $signed(r_a) < $signed(w_op2)};
      3'b011: w_alu = {31'b0, r_a < w_op2};
      3'b100: w_alu = r_a ^ w_op2;
      3'b101: w_alu = r_ir[30] ? w_sra : r_a >> w_sh;
      3'b110: w_alu = r_a | w_op2;
      3'b111: w_alu = r_a & w_op2;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    unique case (w_f3)
      3'b000: w_take = (r_a == r_b);
      3'b001: w_take = (r_a != r_b);
      3'b100: w_take = $signed(r_a) < $signed(r_b);
      3'b101: w_take = $signed(r_a) >= $signed(r_b);
      3'b110: w_take = r_a < r_b;
      3'b111: w_take = r_a >= r_b;
      default: ;
    endcase
  end

  always_comb begin
    w_npc = w_pc4;
    w_res = w_alu;
    if (w_jal || (w_br && w_take)) w_npc = w_pcimm;
    if (w_jalr) w_npc = w_ea & ~32'h1;
    if (w_jal || w_jalr) w_res = w_pc4;
    if (w_lui) w_res = r_imm;
    if (w_auipc) w_res = w_pcimm;
  end

  // f3[1:0]: 00 byte, 01 half, 10 word for both loads and stores
  assign w_mis = ((w_f3[1:0] == 2'b01) && w_ea[0]) ||
                 ((w_f3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
  assign w_fault = w_npc[1] || ((w_ld || w_st) && w_mis);
  assign w_ecall_halt = w_sys && HALT_ON_ECALL;

  logic [31:0] w_wdata, w_lane, w_ldv;
  logic [3:0]  w_wstrb;
  always_comb begin
    w_wdata = r_b;
    w_wstrb = 4'b1111;
    unique case (w_f3[1:0])
      2'b00: begin
        w_wdata = {4{r_b[7:0]}};
        w_wstrb = 4'b0001 << r_ea[1:0];
      end
      2'b01: begin
        w_wdata = {2{r_b[15:0]}};
        w_wstrb = r_ea[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign w_lane = mem_rdata >> {r_ea[1:0], 3'b000};
  always_comb begin
    w_ldv = w_lane;
    unique case (w_f3)
      3'b000: w_ldv = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001: w_ldv = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100: w_ldv = {24'h0, w_lane[7:0]};
      3'b101: w_ldv = {16'h0, w_lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {r_pc[31:2], 2'b00};
    mem_wdata = '0;
    mem_wstrb = '0;
    retire    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_dec_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_ecall_halt) begin
          w_next = S_HALT;
          retire = 1'b1;
        end else if (w_fault) w_next = S_HALT;
        else if (w_ld || w_st) w_next = S_MEM;
        else w_next = S_WB;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = w_st;
        mem_addr = {r_ea[31:2], 2'b00};
        if (w_st) begin
          mem_wdata = w_wdata;
          mem_wstrb = w_wstrb;
        end
        if (mem_ready) w_next = S_WB;
      end
      S_WB: begin
        retire = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
    // reset forces FETCH; keep the bus idle until it is released
    if (!reset_n) mem_req = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_VECTOR;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_res     <= '0;
      r_npc     <= '0;
      r_ea      <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_FETCH: if (mem_ready) r_ir <= mem_rdata;
        S_DECODE: begin
          r_a   <= w_rs1v;
          r_b   <= w_rs2v;
          r_imm <= w_imm;
          if (!w_dec_ok) r_illegal <= 1'b1;
        end
        S_EXEC: begin
          r_npc <= w_npc;
          r_ea  <= w_ea;
          r_res <= w_res;
          if (!w_ecall_halt && w_fault) r_illegal <= 1'b1;
        end
        S_MEM: if (mem_ready && w_ld) r_res <= w_ldv;
        S_WB: begin
          if (w_has_rd && (w_rd != '0))
            r_regs[w_rd[RW-1:0]] <= r_res;
          r_pc <= r_npc;
        end
        default: ;
      endcase
    end
  end

  assign pc_out  = r_pc;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;
endmodule
